// File: rtl/axil_uart_tx.sv
// axil_uart_tx: AXI4-Lite register slave that feeds a byte TX FIFO and a UART transmitter.
//
// Register map (word index addr[7:2]); any other address answers SLVERR, has no effect
// and reads as 0:
//   0x00 TXDATA   W: push wdata[7:0] when wstrb[0]; SLVERR and byte dropped when full. R: 0
//   0x04 STATUS   R: [0] busy, [1] full, [2] empty, [15:8] FIFO level. W: ignored, OKAY
//   0x08 BAUD_DIV RW [15:0] clocks per bit minus 1
//   0x0C CTRL     RW [0] tx_en, [1] irq_en
//
// Ports:
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*          AXI4-Lite write address/data/response channels
//   s_ar*/s_r*               AXI4-Lite read address/data channels
//   uart_txd                 serial output, idle high, LSB first
//   irq                      level interrupt: irq_en & FIFO empty & transmitter idle
//
// Optional feature: define AXIL_UART_TX_PARITY_EN to send an even-parity bit between the
// data bits and the stop bit (11-bit frame). Default build is 8N1.
module axil_uart_tx #(
    parameter int P_ADDR_WIDTH   = 8,
    parameter int P_DATA_WIDTH   = 32,
    parameter int P_FIFO_DEPTH   = 16,
    parameter int P_BAUD_DIV_RST = 867
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [P_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [P_DATA_WIDTH-1:0]   s_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] s_wstrb,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [P_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [2:0]                s_arprot,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [P_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      uart_txd,
    output logic                      irq
);

    localparam int FIFO_AW = $clog2(P_FIFO_DEPTH);
    localparam int IDX_W   = P_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] IDX_TXDATA = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_BAUD   = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(3);
    localparam logic [FIFO_AW:0] FULL_LVL   = (FIFO_AW+1)'(P_FIFO_DEPTH);
    localparam logic [1:0]       RESP_OKAY  = 2'b00;
    localparam logic [1:0]       RESP_SLV   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    logic [7:0]       fifo_mem_r [P_FIFO_DEPTH];
    logic [FIFO_AW:0] wr_ptr_r, rd_ptr_r, level_s;
    logic             empty_s, full_s, push_s, pop_s;
    logic [7:0]       head_s;

    logic                    bvalid_r, rvalid_r;
    logic [1:0]              bresp_r, rresp_r;
    logic [P_DATA_WIDTH-1:0] rdata_r, rd_data_s;
    logic [15:0]             baud_div_r;
    logic [1:0]              ctrl_r;
    logic                    wr_accept_s, wr_err_s, rd_accept_s, rd_err_s;
    logic [IDX_W-1:0]        wr_idx_s, rd_idx_s;

    tx_state_t   state_r, state_n;
    logic [15:0] cnt_r, cnt_n, div_r, div_n;
    logic [2:0]  bit_r, bit_n;
    logic [7:0]  shift_r, shift_n;
    logic        txd_r, txd_n, irq_r, bit_done_s;
`ifdef AXIL_UART_TX_PARITY_EN
    logic        par_r, par_n;
`endif
    logic        unused_s;

    assign unused_s = ^{s_awprot, s_arprot, s_awaddr[1:0], s_araddr[1:0], s_wdata, s_wstrb};

    assign level_s = wr_ptr_r - rd_ptr_r;
    assign empty_s = (level_s == '0);
    assign full_s  = (level_s == FULL_LVL);
    assign head_s  = fifo_mem_r[rd_ptr_r[FIFO_AW-1:0]];

    // Both write channels handshake together, and only while no response is pending.
    assign wr_accept_s = s_awvalid & s_wvalid & ~bvalid_r;
    assign s_awready   = wr_accept_s;
    assign s_wready    = wr_accept_s;
    assign wr_idx_s    = s_awaddr[P_ADDR_WIDTH-1:2];
    assign rd_accept_s = s_arvalid & ~rvalid_r;
    assign s_arready   = rd_accept_s;
    assign rd_idx_s    = s_araddr[P_ADDR_WIDTH-1:2];

    assign s_bvalid = bvalid_r;
    assign s_bresp  = bresp_r;
    assign s_rvalid = rvalid_r;
    assign s_rresp  = rresp_r;
    assign s_rdata  = rdata_r;
    assign uart_txd = txd_r;
    assign irq      = irq_r;

    // Write decode: push request and error response for the accepted write.
    always_comb begin
        push_s   = 1'b0;
        wr_err_s = 1'b0;
        case (wr_idx_s)
            IDX_TXDATA: begin
                if (s_wstrb[0]) begin
                    // Fullness is judged before any pop in this cycle.
                    if (full_s) begin
                        wr_err_s = 1'b1;
                    end else begin
                        push_s = wr_accept_s;
                    end
                end else begin
                    push_s = 1'b0;
                end
            end
            IDX_STATUS, IDX_BAUD, IDX_CTRL: wr_err_s = 1'b0;
            default:    wr_err_s = 1'b1;
        endcase
    end

    // Read decode.
    always_comb begin
        rd_data_s = '0;
        rd_err_s  = 1'b0;
        case (rd_idx_s)
            IDX_TXDATA: rd_data_s = '0;
            IDX_STATUS: begin
                rd_data_s[15:8] = 8'(level_s);
                rd_data_s[2]    = empty_s;
                rd_data_s[1]    = full_s;
                rd_data_s[0]    = (state_r != S_IDLE);
            end
            IDX_BAUD:   rd_data_s[15:0] = baud_div_r;
            IDX_CTRL:   rd_data_s[1:0]  = ctrl_r;
            default:    rd_err_s = 1'b1;
        endcase
    end

    // AXI response registers and software-visible control registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            rvalid_r   <= 1'b0;
            rresp_r    <= RESP_OKAY;
            rdata_r    <= '0;
            baud_div_r <= 16'(P_BAUD_DIV_RST);
            ctrl_r     <= 2'b00;
        end else begin
            if (wr_accept_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_err_s ? RESP_SLV : RESP_OKAY;
                if (wr_idx_s == IDX_BAUD) begin
                    if (s_wstrb[0]) baud_div_r[7:0]  <= s_wdata[7:0];
                    if (s_wstrb[1]) baud_div_r[15:8] <= s_wdata[15:8];
                end
                if (wr_idx_s == IDX_CTRL && s_wstrb[0]) begin
                    ctrl_r <= s_wdata[1:0];
                end
            end else if (bvalid_r && s_bready) begin
                bvalid_r <= 1'b0;
            end
            if (rd_accept_s) begin
                rvalid_r <= 1'b1;
                rresp_r  <= rd_err_s ? RESP_SLV : RESP_OKAY;
                rdata_r  <= rd_data_s;
            end else if (rvalid_r && s_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge ACLK) begin
        if (push_s) fifo_mem_r[wr_ptr_r[FIFO_AW-1:0]] <= s_wdata[7:0];
    end

    // FIFO pointers (one extra bit distinguishes full from empty).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + (FIFO_AW+1)'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + (FIFO_AW+1)'(1);
        end
    end

    assign bit_done_s = (cnt_r == div_r);

    // TX next state: each bit lasts div_r+1 clocks; a frame loads straight from IDLE or STOP.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        div_n   = div_r;
        bit_n   = bit_r;
        shift_n = shift_r;
        txd_n   = txd_r;
        pop_s   = 1'b0;
`ifdef AXIL_UART_TX_PARITY_EN
        par_n   = par_r;
`endif
        case (state_r)
            S_IDLE: begin
                txd_n = 1'b1;
                if (ctrl_r[0] && !empty_s) begin
                    pop_s   = 1'b1;
                    state_n = S_START;
                    txd_n   = 1'b0;
                    cnt_n   = 16'd0;
                    div_n   = baud_div_r;
                    shift_n = head_s;
`ifdef AXIL_UART_TX_PARITY_EN
                    par_n   = even_parity(head_s);
`endif
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                if (bit_done_s) begin
                    state_n = S_DATA;
                    cnt_n   = 16'd0;
                    bit_n   = 3'd0;
                    txd_n   = shift_r[0];
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done_s) begin
                    cnt_n = 16'd0;
                    if (bit_r == 3'd7) begin
`ifdef AXIL_UART_TX_PARITY_EN
                        state_n = S_PARITY;
                        txd_n   = par_r;
`else
                        state_n = S_STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        bit_n   = bit_r + 3'd1;
                        shift_n = {1'b0, shift_r[7:1]};
                        txd_n   = shift_r[1];
                    end
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
`ifdef AXIL_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done_s) begin
                    state_n = S_STOP;
                    cnt_n   = 16'd0;
                    txd_n   = 1'b1;
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done_s) begin
                    cnt_n = 16'd0;
                    // Chain the next frame with no idle gap when data is waiting.
                    if (ctrl_r[0] && !empty_s) begin
                        pop_s   = 1'b1;
                        state_n = S_START;
                        txd_n   = 1'b0;
                        div_n   = baud_div_r;
                        shift_n = head_s;
`ifdef AXIL_UART_TX_PARITY_EN
                        par_n   = even_parity(head_s);
`endif
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

    // TX state register; reset drives the line idle immediately, abandoning any frame.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r <= S_IDLE;
            cnt_r   <= 16'd0;
            div_r   <= 16'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            txd_r   <= 1'b1;
`ifdef AXIL_UART_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            div_r   <= div_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            txd_r   <= txd_n;
`ifdef AXIL_UART_TX_PARITY_EN
            par_r   <= par_n;
`endif
        end
    end

    // Drain interrupt, registered for a glitch-free level.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= ctrl_r[1] & empty_s & (state_r == S_IDLE);
        end
    end

endmodule

// File: tb/tb_axil_uart_tx.sv
module tb_axil_uart_tx;

`ifdef AXIL_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int DEPTH = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        s_awvalid = 1'b0, s_awready;
    logic [7:0]  s_awaddr = 8'h00;
    logic [2:0]  s_awprot = 3'b000;
    logic        s_wvalid = 1'b0, s_wready;
    logic [31:0] s_wdata = 32'h0;
    logic [3:0]  s_wstrb = 4'h0;
    logic        s_bvalid, s_bready = 1'b0;
    logic [1:0]  s_bresp;
    logic        s_arvalid = 1'b0, s_arready;
    logic [7:0]  s_araddr = 8'h00;
    logic [2:0]  s_arprot = 3'b000;
    logic        s_rvalid, s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        uart_txd, irq;

    int checks = 0;
    int errors = 0;
    logic txd_log[$];
    logic irq_log[$];

    axil_uart_tx dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .uart_txd(uart_txd), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    // One sample of the serial line and the interrupt per clock, away from the active edge.
    always @(negedge ACLK) begin
        txd_log.push_back(uart_txd);
        irq_log.push_back(irq);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic txd_at(input int i);
        if (i >= 0 && i < txd_log.size()) return txd_log[i];
        else return 1'bx;
    endfunction

    function automatic logic irq_at(input int i);
        if (i >= 0 && i < irq_log.size()) return irq_log[i];
        else return 1'bx;
    endfunction

    function automatic int find_start();
        for (int i = 0; i < txd_log.size(); i++) begin
            if (txd_log[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic clear_logs();
        txd_log.delete();
        irq_log.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        logic to_s;
        @(negedge ACLK);
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        to_s = 1'b1;
        for (n = 0; n < 50; n++) begin
            #1;
            if (s_awready && s_wready) begin to_s = 1'b0; break; end
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (s_bvalid) break;
        end
        if (n >= 50) to_s = 1'b1;
        resp = s_bresp;
        s_bready = 1'b1;
        @(posedge ACLK); #1;
        s_bready = 1'b0;
        check("write_handshake_timeout", 32'(to_s), 32'd0);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        logic to_s;
        @(negedge ACLK);
        s_araddr = addr; s_arvalid = 1'b1;
        to_s = 1'b1;
        for (n = 0; n < 50; n++) begin
            #1;
            if (s_arready) begin to_s = 1'b0; break; end
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        s_arvalid = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (s_rvalid) break;
        end
        if (n >= 50) to_s = 1'b1;
        data = s_rdata; resp = s_rresp;
        s_rready = 1'b1;
        @(posedge ACLK); #1;
        s_rready = 1'b0;
        check("read_handshake_timeout", 32'(to_s), 32'd0);
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1; each bit div+1 clocks.
    task automatic check_frames(input logic [7:0] bytes[$], input int div, input string tag);
        int s, idx, bad;
        logic exp_bits[$];
        s = find_start();
        check({tag, "_start_seen"}, 32'(s >= 0), 32'd1);
        if (s >= 0) begin
            idx = s;
            foreach (bytes[f]) begin
                exp_bits.delete();
                exp_bits.push_back(1'b0);
                for (int k = 0; k < 8; k++) exp_bits.push_back(((bytes[f] >> k) & 8'd1) != 8'd0);
`ifdef AXIL_UART_TX_PARITY_EN
                exp_bits.push_back(($countones(bytes[f]) % 2) == 1);
`endif
                exp_bits.push_back(1'b1);
                bad = 0;
                foreach (exp_bits[k]) begin
                    for (int j = 0; j <= div; j++) begin
                        if (txd_at(idx) !== exp_bits[k]) bad++;
                        idx++;
                    end
                end
                check($sformatf("%s_frame%0d_bad_samples", tag, f), 32'(bad), 32'd0);
            end
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [7:0]  b;
        logic [7:0]  q[$];
        int div, s, frame, zeros;

        // 1: reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        ARESETN = 1'b1;
        axi_read(8'h08, rd, resp);
        check("rst_baud", rd, 32'h363);
        axi_read(8'h04, rd, resp);
        check("rst_status", rd, 32'h4);
        check("rst_status_resp", 32'(resp), 32'd0);

        // 2: single frames, the fixed 0xA5 case then random bytes and divisors (incl. 0)
        axi_write(8'h08, 32'd3, 4'hF, resp);
        check("baud_wr_resp", 32'(resp), 32'd0);
        axi_write(8'h0C, 32'd1, 4'hF, resp);
        check("ctrl_wr_resp", 32'(resp), 32'd0);
        clear_logs();
        axi_write(8'h00, 32'hA5, 4'h1, resp);
        check("push_a5_resp", 32'(resp), 32'd0);
        wait_cycles(NBITS * 4 + 20);
        q = '{8'hA5};
        check_frames(q, 3, "a5");
        for (int t = 0; t < 3; t++) begin
            div = (t == 0) ? 0 : int'($urandom_range(1, 5));
            b = 8'($urandom);
            axi_write(8'h08, 32'(div), 4'h3, resp);
            clear_logs();
            axi_write(8'h00, {24'h0, b}, 4'h1, resp);
            check("push_rand_resp", 32'(resp), 32'd0);
            wait_cycles(NBITS * (div + 1) + 20);
            q = '{b};
            check_frames(q, div, $sformatf("rand%0d", t));
        end

        // 3: fill the FIFO while disabled, overflow, then drain back-to-back
        div = int'($urandom_range(0, 2));
        axi_write(8'h08, 32'(div), 4'hF, resp);
        axi_write(8'h0C, 32'd0, 4'hF, resp);
        q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            axi_write(8'h00, {24'h0, b}, 4'h1, resp);
            check("fill_resp", 32'(resp), 32'd0);
            q.push_back(b);
        end
        axi_read(8'h04, rd, resp);
        check("full_status", rd, (32'(DEPTH) << 8) | 32'h2);
        axi_write(8'h00, 32'hEE, 4'h1, resp);
        check("overflow_resp", 32'(resp), 32'd2);
        axi_read(8'h04, rd, resp);
        check("status_after_overflow", rd, (32'(DEPTH) << 8) | 32'h2);
        clear_logs();
        axi_write(8'h0C, 32'd1, 4'hF, resp);
        wait_cycles(DEPTH * NBITS * (div + 1) + 40);
        check_frames(q, div, "burst");
        axi_read(8'h04, rd, resp);
        check("drained_status", rd, 32'h4);

        // 4: unmapped addresses
        axi_write(8'hFF, 32'hDEADBEEF, 4'hF, resp);
        check("bad_wr_resp", 32'(resp), 32'd2);
        axi_read(8'h08, rd, resp);
        check("baud_unchanged", rd, 32'(div));
        axi_read(8'h0C, rd, resp);
        check("ctrl_unchanged", rd, 32'd1);
        axi_read(8'hFC, rd, resp);
        check("bad_rd_resp", 32'(resp), 32'd2);
        check("bad_rd_data", rd, 32'd0);
        axi_read(8'h00, rd, resp);
        check("txdata_rd", rd, 32'd0);
        check("txdata_rd_resp", 32'(resp), 32'd0);
        axi_write(8'h04, 32'hFFFFFFFF, 4'hF, resp);
        check("status_wr_resp", 32'(resp), 32'd0);

        // 5: drain interrupt timing
        axi_write(8'h08, 32'd3, 4'hF, resp);
        axi_write(8'h0C, 32'd3, 4'hF, resp);
        wait_cycles(2);
        @(negedge ACLK);
        check("irq_idle_empty", 32'(irq), 32'd1);
        clear_logs();
        axi_write(8'h00, 32'h55, 4'h1, resp);
        wait_cycles(NBITS * 4 + 20);
        q = '{8'h55};
        check_frames(q, 3, "irq55");
        s = find_start();
        frame = NBITS * 4;
        check("irq_mid_frame", 32'(irq_at(s + frame / 2)), 32'd0);
        check("irq_last_stop_clk", 32'(irq_at(s + frame - 1)), 32'd0);
        check("irq_first_idle_clk", 32'(irq_at(s + frame)), 32'd0);
        check("irq_one_clk_later", 32'(irq_at(s + frame + 1)), 32'd1);
        axi_write(8'h0C, 32'd1, 4'hF, resp);
        @(negedge ACLK);
        check("irq_disabled", 32'(irq), 32'd0);

        // 6: reset in the middle of the data bits
        axi_write(8'h08, 32'd7, 4'hF, resp);
        axi_write(8'h00, 32'h00, 4'h1, resp);
        s = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge ACLK);
            if (uart_txd === 1'b0) begin s = n; break; end
        end
        check("rst_frame_started", 32'(s >= 0), 32'd1);
        repeat (24) @(negedge ACLK);
        check("pre_reset_txd", 32'(uart_txd), 32'd0);
        ARESETN = 1'b0;
        #1;
        check("reset_txd_immediate", 32'(uart_txd), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        clear_logs();
        axi_read(8'h04, rd, resp);
        check("post_reset_status", rd, 32'h4);
        axi_read(8'h08, rd, resp);
        check("post_reset_baud", rd, 32'h363);
        axi_read(8'h0C, rd, resp);
        check("post_reset_ctrl", rd, 32'd0);
        wait_cycles(20);
        zeros = 0;
        foreach (txd_log[i]) if (txd_log[i] !== 1'b1) zeros++;
        check("post_reset_line_idle", 32'(zeros), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
